multi_ch_window_checker: RTL and testbench

MULTI_CH_WINDOW_CHECKER -- requirements
Module: multi_ch_window_checker

---
 rtl/multi_ch_window_checker.sv | 150 +++++++++++++++
 tb/tb_multi_ch_window_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_window_checker.sv
// Multi-channel event window checker: each channel arms on a trigger, then judges
// the first qualifying event edge against its condition bits, or times out.
module multi_ch_window_checker #(
    parameter int NUM_CH   = 4,
    parameter int COND_W   = 2,
    parameter int TIMEOUT  = 16,
    parameter int EDGE_ANY = 1,
    parameter int COND_AND = 0,
    parameter int CNT_W    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_trig,
    input  logic [NUM_CH-1:0]        i_evt,
    input  logic [NUM_CH*COND_W-1:0] i_cond,
    input  logic                     i_clr,
    output logic [NUM_CH-1:0]        o_armed,
    output logic [NUM_CH-1:0]        o_pass_p,
    output logic [NUM_CH-1:0]        o_fail_p,
    output logic [NUM_CH-1:0]        o_tmo_p,
    output logic [NUM_CH-1:0]        o_err_sticky,
    output logic [CNT_W-1:0]         o_pass_cnt,
    output logic [CNT_W-1:0]         o_fail_cnt
);

    typedef enum logic {S_IDLE, S_ARMED} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam int          SUM_W    = CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = {6'b0, {CNT_W{1'b1}}};

    state_t            r_state     [NUM_CH];
    state_t            w_state_nxt [NUM_CH];
    logic [15:0]       r_timer     [NUM_CH];
    logic [15:0]       w_timer_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_evt_q;
    logic [NUM_CH-1:0] r_armed, r_pass_p, r_fail_p, r_tmo_p, r_err_sticky;
    logic [CNT_W-1:0]  r_pass_cnt, r_fail_cnt;
    logic [NUM_CH-1:0] w_edge, w_cond_ok, w_armed_nxt;
    logic [NUM_CH-1:0] w_pass, w_fail, w_tmo;
    logic [SUM_W-1:0]  w_pass_sum, w_fail_sum;
    logic [CNT_W-1:0]  w_pass_cnt_nxt, w_fail_cnt_nxt;

    function automatic logic [5:0] popcount(input logic [NUM_CH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        logic [COND_W-1:0] v_cond;
        w_edge    = (EDGE_ANY != 0) ? (i_evt ^ r_evt_q) : (i_evt & ~r_evt_q);
        w_cond_ok = '0;
        v_cond    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v_cond       = i_cond[i*COND_W +: COND_W];
            w_cond_ok[i] = (COND_AND != 0) ? (&v_cond) : (|v_cond);
        end
    end

    // Per-channel next state; an edge always outranks an expiring window.
    always_comb begin
        w_pass      = '0;
        w_fail      = '0;
        w_tmo       = '0;
        w_armed_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            case (r_state[i])
                S_IDLE: begin
                    if (i_trig[i]) begin
                        w_state_nxt[i] = S_ARMED;
                        w_timer_nxt[i] = '0;
                    end
                end
                S_ARMED: begin
                    if (w_edge[i]) begin
                        w_pass[i]      = w_cond_ok[i];
                        w_fail[i]      = ~w_cond_ok[i];
                        w_state_nxt[i] = S_IDLE;
                    end else if (r_timer[i] == TMO_LAST) begin
                        w_tmo[i]       = 1'b1;
                        w_state_nxt[i] = S_IDLE;
                    end else begin
                        w_timer_nxt[i] = r_timer[i] + 16'd1;
                    end
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
            w_armed_nxt[i] = (w_state_nxt[i] == S_ARMED);
        end
    end

    always_comb begin
        w_pass_sum     = SUM_W'(r_pass_cnt) + SUM_W'(popcount(w_pass));
        w_fail_sum     = SUM_W'(r_fail_cnt) + SUM_W'(popcount(w_fail)) + SUM_W'(popcount(w_tmo));
        w_pass_cnt_nxt = (w_pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_pass_sum[CNT_W-1:0];
        w_fail_cnt_nxt = (w_fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_fail_sum[CNT_W-1:0];
    end

    // clr only touches the aggregate results, never the channel FSMs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_timer[i] <= '0;
            end
            r_evt_q      <= '0;
            r_armed      <= '0;
            r_pass_p     <= '0;
            r_fail_p     <= '0;
            r_tmo_p      <= '0;
            r_err_sticky <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            r_evt_q  <= i_evt;
            r_armed  <= w_armed_nxt;
            r_pass_p <= w_pass;
            r_fail_p <= w_fail;
            r_tmo_p  <= w_tmo;
            if (i_clr) begin
                r_err_sticky <= '0;
                r_pass_cnt   <= '0;
                r_fail_cnt   <= '0;
            end else begin
                r_err_sticky <= r_err_sticky | w_fail | w_tmo;
                r_pass_cnt   <= w_pass_cnt_nxt;
                r_fail_cnt   <= w_fail_cnt_nxt;
            end
        end
    end

    assign o_armed      = r_armed;
    assign o_pass_p     = r_pass_p;
    assign o_fail_p     = r_fail_p;
    assign o_tmo_p      = r_tmo_p;
    assign o_err_sticky = r_err_sticky;
    assign o_pass_cnt   = r_pass_cnt;
    assign o_fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_multi_ch_window_checker.sv
// Bench for multi_ch_window_checker: two configurations driven with the same
// directed and random stimulus, checked through a queue against a window model.
module tb_multi_ch_window_checker;

    localparam int TMO = 8;
    localparam int CMAX = 15;

    typedef struct packed {
        logic [1:0] armed;
        logic [1:0] pass;
        logic [1:0] fail;
        logic [1:0] tmo;
        logic [1:0] sticky;
        logic [3:0] pcnt;
        logic [3:0] fcnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] trig;
    logic [1:0] evt;
    logic [3:0] cond;
    logic       clr;

    logic [1:0] armed0, pass0, fail0, tmo0, sticky0;
    logic [3:0] pcnt0, fcnt0;
    logic [1:0] armed1, pass1, fail1, tmo1, sticky1;
    logic [3:0] pcnt1, fcnt1;

    exp_t expQ0[$];
    exp_t expQ1[$];

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    logic [1:0] evtLvl = 2'b00;

    // Model state, indexed [config][channel]; config 0 = any-toggle/OR, 1 = rising/AND
    int armedM  [2][2];
    int armCyc  [2][2];
    int prevEvt [2][2];
    int stickyM [2][2];
    int pCnt    [2];
    int fCnt    [2];

    multi_ch_window_checker #(
        .NUM_CH(2), .COND_W(2), .TIMEOUT(TMO), .EDGE_ANY(1), .COND_AND(0), .CNT_W(4)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_trig(trig), .i_evt(evt), .i_cond(cond), .i_clr(clr),
        .o_armed(armed0), .o_pass_p(pass0), .o_fail_p(fail0), .o_tmo_p(tmo0),
        .o_err_sticky(sticky0), .o_pass_cnt(pcnt0), .o_fail_cnt(fcnt0)
    );

    multi_ch_window_checker #(
        .NUM_CH(2), .COND_W(2), .TIMEOUT(TMO), .EDGE_ANY(0), .COND_AND(1), .CNT_W(4)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_trig(trig), .i_evt(evt), .i_cond(cond), .i_clr(clr),
        .o_armed(armed1), .o_pass_p(pass1), .o_fail_p(fail1), .o_tmo_p(tmo1),
        .o_err_sticky(sticky1), .o_pass_cnt(pcnt1), .o_fail_cnt(fcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Window rule: armed at cycle A, the deciding cycles are A+1..A+TMO; no edge by A+TMO times out.
    function automatic exp_t modelStep(input int k, input logic [1:0] tg, input logic [1:0] ev,
                                       input logic [3:0] cd, input logic cl, input logic rs);
        exp_t e;
        int np, nf;
        logic edgeSeen, ok;
        logic [1:0] c;
        e  = '0;
        np = 0;
        nf = 0;
        if (rs) begin
            for (int ch = 0; ch < 2; ch++) begin
                armedM[k][ch]  = 0;
                prevEvt[k][ch] = 0;
                stickyM[k][ch] = 0;
            end
            pCnt[k] = 0;
            fCnt[k] = 0;
            return e;
        end
        for (int ch = 0; ch < 2; ch++) begin
            edgeSeen = (k == 0) ? (int'(ev[ch]) != prevEvt[k][ch]) : (ev[ch] && prevEvt[k][ch] == 0);
            prevEvt[k][ch] = int'(ev[ch]);
            c  = cd[ch*2 +: 2];
            ok = (k == 0) ? (c != 2'b00) : (c == 2'b11);
            if (armedM[k][ch] != 0) begin
                if (edgeSeen) begin
                    if (ok) e.pass[ch] = 1'b1;
                    else    e.fail[ch] = 1'b1;
                    armedM[k][ch] = 0;
                end else if (cyc == armCyc[k][ch] + TMO) begin
                    e.tmo[ch]     = 1'b1;
                    armedM[k][ch] = 0;
                end
            end else if (tg[ch]) begin
                armedM[k][ch] = 1;
                armCyc[k][ch] = cyc;
            end
            if (e.pass[ch]) np++;
            if (e.fail[ch] || e.tmo[ch]) nf++;
            if (cl) stickyM[k][ch] = 0;
            else if (e.fail[ch] || e.tmo[ch]) stickyM[k][ch] = 1;
            e.armed[ch]  = (armedM[k][ch] != 0);
            e.sticky[ch] = (stickyM[k][ch] != 0);
        end
        if (cl) begin
            pCnt[k] = 0;
            fCnt[k] = 0;
        end else begin
            pCnt[k] = (pCnt[k] + np > CMAX) ? CMAX : pCnt[k] + np;
            fCnt[k] = (fCnt[k] + nf > CMAX) ? CMAX : fCnt[k] + nf;
        end
        e.pcnt = 4'(pCnt[k]);
        e.fcnt = 4'(fCnt[k]);
        return e;
    endfunction

    task automatic applyStimulus(input logic [1:0] tg, input logic [1:0] ev, input logic [3:0] cd,
                                 input logic cl, input logic rs);
        @(negedge clk);
        trig = tg;
        evt  = ev;
        cond = cd;
        clr  = cl;
        rst  = rs;
        evtLvl = ev;
        expQ0.push_back(modelStep(0, tg, ev, cd, cl, rs));
        expQ1.push_back(modelStep(1, tg, ev, cd, cl, rs));
        cyc++;
    endtask

    task automatic idle(input int n, input logic [3:0] cd);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, evtLvl, cd, 1'b0, 1'b0);
    endtask

    // Monitor: after each active edge, pop the expectation issued for it and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ0.size() > 0) begin
                e = expQ0.pop_front();
                checkOutput("c0.armed",  int'(armed0),  int'(e.armed));
                checkOutput("c0.pass_p", int'(pass0),   int'(e.pass));
                checkOutput("c0.fail_p", int'(fail0),   int'(e.fail));
                checkOutput("c0.tmo_p",  int'(tmo0),    int'(e.tmo));
                checkOutput("c0.sticky", int'(sticky0), int'(e.sticky));
                checkOutput("c0.pcnt",   int'(pcnt0),   int'(e.pcnt));
                checkOutput("c0.fcnt",   int'(fcnt0),   int'(e.fcnt));
            end
            if (expQ1.size() > 0) begin
                e = expQ1.pop_front();
                checkOutput("c1.armed",  int'(armed1),  int'(e.armed));
                checkOutput("c1.pass_p", int'(pass1),   int'(e.pass));
                checkOutput("c1.fail_p", int'(fail1),   int'(e.fail));
                checkOutput("c1.tmo_p",  int'(tmo1),    int'(e.tmo));
                checkOutput("c1.sticky", int'(sticky1), int'(e.sticky));
                checkOutput("c1.pcnt",   int'(pcnt1),   int'(e.pcnt));
                checkOutput("c1.fcnt",   int'(fcnt1),   int'(e.fcnt));
            end
        end
    end

    initial begin
        logic [1:0] tg, tog;
        logic       cl, rs;
        rst  = 1'b1;
        clr  = 1'b0;
        trig = 2'b00;
        evt  = 2'b00;
        cond = 4'b0000;

        applyStimulus(2'b00, 2'b00, 4'b0000, 1'b0, 1'b1);
        applyStimulus(2'b00, 2'b00, 4'b0000, 1'b0, 1'b1);

        // ch0 arm, rising edge three cycles later with cond 01
        applyStimulus(2'b01, 2'b00, 4'b0001, 1'b0, 1'b0);
        idle(2, 4'b0001);
        applyStimulus(2'b00, 2'b01, 4'b0001, 1'b0, 1'b0);
        idle(2, 4'b0000);

        // ch0 fail on a toggle with cond 00, then clr
        applyStimulus(2'b01, evtLvl, 4'b0000, 1'b0, 1'b0);
        idle(1, 4'b0000);
        applyStimulus(2'b00, evtLvl ^ 2'b01, 4'b0000, 1'b0, 1'b0);
        idle(3, 4'b0000);
        applyStimulus(2'b00, evtLvl, 4'b0000, 1'b1, 1'b0);

        // ch1 timeout, then ch1 edge on the final window cycle
        applyStimulus(2'b10, evtLvl, 4'b0000, 1'b0, 1'b0);
        idle(10, 4'b0000);
        applyStimulus(2'b10, evtLvl, 4'b1111, 1'b0, 1'b0);
        idle(TMO - 1, 4'b1111);
        applyStimulus(2'b00, evtLvl ^ 2'b10, 4'b1111, 1'b0, 1'b0);
        idle(2, 4'b0000);

        // both channels pass together, repeated until the pass counter saturates
        for (int r = 0; r < 10; r++) begin
            applyStimulus(2'b11, 2'b00, 4'b1111, 1'b0, 1'b0);
            applyStimulus(2'b00, 2'b11, 4'b1111, 1'b0, 1'b0);
            applyStimulus(2'b00, 2'b00, 4'b1111, 1'b0, 1'b0);
        end
        applyStimulus(2'b00, evtLvl, 4'b0000, 1'b1, 1'b0);

        // falling edge while armed is ignored by the rising-only config
        applyStimulus(2'b00, 2'b01, 4'b0001, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, 4'b0001, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 4'b0001, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b01, 4'b0001, 1'b0, 1'b0);
        idle(2, 4'b0000);

        // reset mid-window, then trig coinciding with an edge
        applyStimulus(2'b11, evtLvl, 4'b0000, 1'b0, 1'b0);
        idle(3, 4'b0000);
        applyStimulus(2'b00, evtLvl ^ 2'b11, 4'b1111, 1'b1, 1'b1);
        applyStimulus(2'b11, evtLvl ^ 2'b11, 4'b1111, 1'b0, 1'b0);
        idle(10, 4'b0000);

        for (int n = 0; n < 3000; n++) begin
            tg  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            tog = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            cl  = ($urandom_range(0, 49) == 0);
            rs  = ($urandom_range(0, 199) == 0);
            applyStimulus(tg, evtLvl ^ tog, 4'($urandom_range(0, 15)), cl, rs);
        end

        for (int i = 0; i < 5 && (expQ0.size() > 0 || expQ1.size() > 0); i++) @(posedge clk);
        #2;
        if (expQ0.size() > 0 || expQ1.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d/%0d expectations left, required 0", expQ0.size(), expQ1.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
